// File: rtl/uart_ctrl_pkg.sv
// Shared constants, register map and FSM state type for the UART bus sequencer.
// Optional macro UART_CTRL_IRQ_WAIT_EN selects the tx_irq wait path.
package uart_ctrl_pkg;

    localparam logic [31:0] REG_DIV    = 32'h00;
    localparam logic [31:0] REG_TXDATA = 32'h10;
    localparam logic [31:0] REG_STATUS = 32'h14;
    localparam logic [31:0] REG_CFG    = 32'h1C;

    localparam int STATUS_TX_BUSY_BIT = 1;

    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;

    typedef enum logic [2:0] {
        RST,
        WR_DIV,
        WR_CFG,
        IDLE,
        POLL_AR,
        POLL_R,
        WAIT_IRQ,
        WR_TX
    } state_t;

endpackage

// File: rtl/uart_ctrl_if.sv
// AXI4 single-beat subset (32-bit addr/data, 5-bit id) between the
// sequencer (master) and the UART slave port.
interface uart_ctrl_if;

    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic [4:0]  aw_id;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;

    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;

    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
    logic [4:0]  b_id;

    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [4:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;

    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic [4:0]  r_id;
    logic        r_last;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp, b_id,
        output b_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_id, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp, b_id,
        input  b_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_data, r_resp, r_id, r_last,
        input  r_ready
    );

endinterface

// File: rtl/uart_ctrl_axi_wr.sv
// Single-beat AXI write engine: aw and w complete independently,
// then the B response is taken once both have been accepted.
module uart_ctrl_axi_wr
    import uart_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        done,
    output logic        resp_err,
    output logic        active,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [31:0] aw_addr,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [1:0]  b_resp
);

    logic        aw_pend_q;
    logic        w_pend_q;
    logic        active_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;

    assign aw_valid = aw_pend_q;
    assign w_valid  = w_pend_q;
    assign aw_addr  = addr_q;
    assign w_data   = data_q;
    assign active   = active_q;
    assign b_ready  = active_q && !aw_pend_q && !w_pend_q;
    assign done     = b_ready && b_valid;
    assign resp_err = done && (b_resp != OKAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            active_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (start && !active_q) begin
            active_q  <= 1'b1;
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
            addr_q    <= addr;
            data_q    <= data;
        end else begin
            if (aw_pend_q && aw_ready) aw_pend_q <= 1'b0;
            if (w_pend_q && w_ready)   w_pend_q  <= 1'b0;
            // payloads return to zero between transfers
            if (done) begin
                active_q <= 1'b0;
                addr_q   <= '0;
                data_q   <= '0;
            end
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// UART bus-master sequencer: boot config, then status-polled byte writes.
// Define UART_CTRL_IRQ_WAIT_EN to wait on tx_irq instead of polling STATUS.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h1_0000,
    parameter logic [31:0] DIV_INIT = 32'hA2C,
    parameter logic [31:0] CFG_INIT = 32'h20,
    parameter int          POLL_MAX = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_ctrl_if.master bus,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        cfg_req,
    input  logic [31:0] cfg_div,
    input  logic [31:0] cfg_mode,
    output logic        busy,
    output logic        err
`ifdef UART_CTRL_IRQ_WAIT_EN
    ,
    input  logic        tx_irq
`endif
);

    localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

    state_t      state_q, state_n;
    logic [7:0]  byte_q, byte_n;
    logic [31:0] div_q, div_n;
    logic [31:0] mode_q, mode_n;
    logic [15:0] cnt_q, cnt_n, cnt_inc;
    logic        err_q, err_n;
`ifdef UART_CTRL_IRQ_WAIT_EN
    logic        sent_q, sent_n;
`endif

    logic        wr_start, wr_done, wr_err, wr_active;
    logic [31:0] wr_addr, wr_data;
    logic        unused;

    assign cnt_inc  = cnt_q + 16'd1;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign s_ready  = (state_q == IDLE) && !cfg_req && s_valid;
    assign wr_start = (state_q inside {WR_DIV, WR_CFG, WR_TX}) && !wr_active;

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        unique case (state_q)
            WR_DIV: begin
                wr_addr = BASE + REG_DIV;
                wr_data = div_q;
            end
            WR_CFG: begin
                wr_addr = BASE + REG_CFG;
                wr_data = mode_q;
            end
            WR_TX: begin
                wr_addr = BASE + REG_TXDATA;
                wr_data = {24'h0, byte_q};
            end
            default: ;
        endcase
    end

    uart_ctrl_axi_wr u_wr (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (wr_start),
        .addr     (wr_addr),
        .data     (wr_data),
        .done     (wr_done),
        .resp_err (wr_err),
        .active   (wr_active),
        .aw_valid (bus.aw_valid),
        .aw_ready (bus.aw_ready),
        .aw_addr  (bus.aw_addr),
        .w_valid  (bus.w_valid),
        .w_ready  (bus.w_ready),
        .w_data   (bus.w_data),
        .b_valid  (bus.b_valid),
        .b_ready  (bus.b_ready),
        .b_resp   (bus.b_resp)
    );

    assign bus.aw_id    = '0;
    assign bus.aw_len   = '0;
    assign bus.aw_size  = bus.aw_valid ? SIZE_WORD : '0;
    assign bus.aw_burst = bus.aw_valid ? BURST_INCR : '0;
    assign bus.w_strb   = bus.w_valid ? 4'hF : '0;
    assign bus.w_last   = bus.w_valid;

    assign bus.ar_valid = (state_q == POLL_AR);
    assign bus.ar_addr  = bus.ar_valid ? BASE + REG_STATUS : '0;
    assign bus.ar_id    = '0;
    assign bus.ar_len   = '0;
    assign bus.ar_size  = bus.ar_valid ? SIZE_WORD : '0;
    assign bus.ar_burst = bus.ar_valid ? BURST_INCR : '0;
    assign bus.r_ready  = (state_q == POLL_R);

    assign unused = ^{bus.b_id, bus.r_id, bus.r_last, bus.r_data,
                      bus.r_valid, bus.r_resp, bus.ar_ready};

    always_comb begin
        state_n = state_q;
        byte_n  = byte_q;
        div_n   = div_q;
        mode_n  = mode_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
`ifdef UART_CTRL_IRQ_WAIT_EN
        sent_n  = sent_q;
`endif
        unique case (state_q)
            RST: state_n = WR_DIV;
            WR_DIV: begin
                if (wr_done) begin
                    if (wr_err) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = WR_CFG;
                    end
                end
            end
            WR_CFG: begin
                if (wr_done) begin
                    err_n   = err_q | wr_err;
                    state_n = IDLE;
                end
            end
            WR_TX: begin
                if (wr_done) begin
                    err_n   = err_q | wr_err;
                    state_n = IDLE;
`ifdef UART_CTRL_IRQ_WAIT_EN
                    sent_n  = 1'b1;
`endif
                end
            end
            IDLE: begin
                if (cfg_req) begin
                    div_n   = cfg_div;
                    mode_n  = cfg_mode;
                    state_n = WR_DIV;
                end else if (s_valid) begin
                    byte_n  = s_data;
                    cnt_n   = '0;
`ifdef UART_CTRL_IRQ_WAIT_EN
                    state_n = WAIT_IRQ;
`else
                    state_n = POLL_AR;
`endif
                end
            end
`ifdef UART_CTRL_IRQ_WAIT_EN
            // the very first byte needs no prior completion interrupt
            WAIT_IRQ: begin
                if (!sent_q || tx_irq) begin
                    state_n = WR_TX;
                end else if (cnt_inc == POLL_LIM) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
`else
            POLL_AR: begin
                if (bus.ar_ready) state_n = POLL_R;
            end
            POLL_R: begin
                if (bus.r_valid) begin
                    if (bus.r_resp != OKAY) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else if (bus.r_data[STATUS_TX_BUSY_BIT]) begin
                        if (cnt_inc == POLL_LIM) begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            cnt_n   = cnt_inc;
                            state_n = POLL_AR;
                        end
                    end else begin
                        state_n = WR_TX;
                    end
                end
            end
`endif
            default: state_n = RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
            byte_q  <= '0;
            div_q   <= DIV_INIT;
            mode_q  <= CFG_INIT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef UART_CTRL_IRQ_WAIT_EN
            sent_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            byte_q  <= byte_n;
            div_q   <= div_n;
            mode_q  <= mode_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
`ifdef UART_CTRL_IRQ_WAIT_EN
            sent_q  <= sent_n;
`endif
        end
    end

endmodule
